// File: rtl/clkdiv_multi_pkg.sv
// Shared constants for the multi-channel clock divider: default channel count,
// counter width and post-reset divisor/duty.
package clkdiv_multi_pkg;

  localparam int unsigned CLKDIV_NCH      = 2;
  localparam int unsigned CLKDIV_WIDTH    = 28;
  localparam int unsigned CLKDIV_DEF_DIV  = 2;
  localparam int unsigned CLKDIV_DEF_DUTY = 1;

  function automatic int unsigned ch_idx_w(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: free-running counter, registered output and tick, and a
// shadowed (div, duty) pair that is only committed at a period boundary.
module clkdiv_chan
  import clkdiv_multi_pkg::*;
#(
  parameter int unsigned WIDTH    = CLKDIV_WIDTH,
  parameter int unsigned DEF_DIV  = CLKDIV_DEF_DIV,
  parameter int unsigned DEF_DUTY = CLKDIV_DEF_DUTY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic [WIDTH-1:0] duty_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);

  logic [1:0]       rsync_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, duty_q, sdiv_q, sduty_q;
  logic [WIDTH-1:0] div_eff_s;
  logic             pend_q, pend_d;
  logic             out_q, tick_q;
  logic             run_s, wrap_s, apply_s, load_s;

  // The counter only runs once reset release has passed the synchroniser.
  assign run_s     = en_i & rsync_q[1];
  assign div_eff_s = (div_q == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : div_q;
  assign wrap_s    = (cnt_q >= (div_eff_s - {{(WIDTH-1){1'b0}}, 1'b1}));
  // A stopped channel commits straight away; a running one waits for its wrap.
  assign apply_s   = pend_q & (~run_s | wrap_s);
  assign load_s    = wr_i & ~pend_q;

  // Counter and pending-flag next state.
  always_comb begin
    cnt_d  = {WIDTH{1'b0}};
    pend_d = pend_q;
    if (run_s && !wrap_s) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {WIDTH{1'b0}};
    end
    if (apply_s) begin
      pend_d = 1'b0;
    end else if (load_s) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Reset-release synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsync_q <= 2'b00;
    end else begin
      rsync_q <= {rsync_q[0], 1'b1};
    end
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= {WIDTH{1'b0}};
      div_q   <= WIDTH'(DEF_DIV);
      duty_q  <= WIDTH'(DEF_DUTY);
      sdiv_q  <= WIDTH'(DEF_DIV);
      sduty_q <= WIDTH'(DEF_DUTY);
      pend_q  <= 1'b0;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      out_q  <= run_s & (cnt_q < duty_q);
      tick_q <= run_s & (cnt_q == {WIDTH{1'b0}});
      if (apply_s) begin
        div_q  <= sdiv_q;
        duty_q <= sduty_q;
      end
      if (load_s) begin
        sdiv_q  <= div_i;
        sduty_q <= duty_i;
      end
    end
  end

  assign pend_o = pend_q;
  assign clk_o  = out_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel clock divider: routes configuration writes to per-channel
// dividers and reports whether the addressed channel can take a write.
module clkdiv_multi
  import clkdiv_multi_pkg::*;
#(
  parameter int unsigned NCH      = CLKDIV_NCH,
  parameter int unsigned WIDTH    = CLKDIV_WIDTH,
  parameter int unsigned DEF_DIV  = CLKDIV_DEF_DIV,
  parameter int unsigned DEF_DUTY = CLKDIV_DEF_DUTY,
  localparam int unsigned CHW     = ch_idx_w(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ch_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  logic [NCH-1:0] pend_s;
  logic [NCH-1:0] wr_s;

  // Write decode; an address with no matching channel stays ready and is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    wr_s      = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CHW'(i)) begin
        cfg_ready = ~pend_s[i];
        wr_s[i]   = cfg_valid & ~pend_s[i];
      end else begin
        wr_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clkdiv_chan #(
      .WIDTH    (WIDTH),
      .DEF_DIV  (DEF_DIV),
      .DEF_DUTY (DEF_DUTY)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (ch_en[g]),
      .wr_i   (wr_s[g]),
      .div_i  (cfg_div),
      .duty_i (cfg_duty),
      .pend_o (pend_s[g]),
      .clk_o  (clk_out[g]),
      .tick_o (tick[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed and randomized bench for clkdiv_multi with a per-channel reference
// model of period, duty and deferred configuration behaviour.
module tb_clkdiv_multi;

  localparam int NCH   = 3;
  localparam int WIDTH = 8;
  localparam int DDIV  = 2;
  localparam int DDUTY = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NCH-1:0]   ch_en = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = '0;
  logic [WIDTH-1:0] cfg_div = '0;
  logic [WIDTH-1:0] cfg_duty = '0;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: counter position, live and queued settings per channel
  int m_cnt[NCH], m_div[NCH], m_duty[NCH], m_sdiv[NCH], m_sduty[NCH];
  bit m_pend[NCH], m_out[NCH], m_tick[NCH];
  int age;
  int c_tick[NCH], c_high[NCH];

  clkdiv_multi #(
    .NCH(NCH), .WIDTH(WIDTH), .DEF_DIV(DDIV), .DEF_DUTY(DDUTY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_duty(cfg_duty), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_div[i] = DDIV; m_duty[i] = DDUTY;
      m_sdiv[i] = DDIV; m_sduty[i] = DDUTY;
      m_pend[i] = 0; m_out[i] = 0; m_tick[i] = 0;
    end
    age = 0;
  endtask

  task automatic check_all();
    int exp_rdy;
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("clk_out[%0d]", i), clk_out[i], m_out[i]);
      chk($sformatf("tick[%0d]", i), tick[i], m_tick[i]);
    end
    exp_rdy = 1;
    if (cfg_ch < NCH) exp_rdy = m_pend[cfg_ch] ? 0 : 1;
    chk("cfg_ready", cfg_ready, exp_rdy);
  endtask

  // one clock: advance the model by the rules, then compare after the edge
  task automatic cycle();
    int  period;
    bit  run, last, acc, cp;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        run    = ch_en[i] && (age >= 2);
        period = (m_div[i] == 0) ? 1 : m_div[i];
        last   = (m_cnt[i] + 1 >= period);
        acc    = cfg_valid && (cfg_ch == i) && !m_pend[i];
        m_out[i]  = run && (m_cnt[i] < m_duty[i]);
        m_tick[i] = run && (m_cnt[i] == 0);
        cp     = m_pend[i] && (!run || last);
        m_cnt[i] = (run && !last) ? m_cnt[i] + 1 : 0;
        if (cp) begin
          m_div[i] = m_sdiv[i]; m_duty[i] = m_sduty[i]; m_pend[i] = 0;
        end else if (acc) begin
          m_sdiv[i] = cfg_div; m_sduty[i] = cfg_duty; m_pend[i] = 1;
        end
      end
      if (age < 2) age++;
    end
    #1;
    check_all();
  endtask

  task automatic count(input int n);
    for (int i = 0; i < NCH; i++) begin c_tick[i] = 0; c_high[i] = 0; end
    repeat (n) begin
      cycle();
      for (int i = 0; i < NCH; i++) begin
        c_tick[i] += int'(tick[i]);
        c_high[i] += int'(clk_out[i]);
      end
    end
  endtask

  task automatic wr(input int ch, input int dv, input int dt);
    int k;
    cfg_ch = 2'(ch); cfg_div = WIDTH'(dv); cfg_duty = WIDTH'(dt); cfg_valid = 1'b1;
    #1;
    k = 0;
    while (cfg_ready !== 1'b1 && k < 40) begin cycle(); k++; end
    chk("wr_ready", cfg_ready, 1);
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int need_div);
    int k;
    k = 0;
    while (!(tick[ch] === 1'b1 && m_div[ch] == need_div) && k < 40) begin cycle(); k++; end
    chk("wait_tick", (tick[ch] === 1'b1 && m_div[ch] == need_div), 1);
  endtask

  initial begin
    logic [13:0] exp_seq;
    exp_seq = 14'b10000010001000;

    // reset defaults
    #3 rst_n = 1'b0;
    #20;
    model_reset();
    check_all();
    @(posedge clk); #1;
    ch_en = 3'b001;
    rst_n = 1'b1;
    repeat (4) cycle();
    count(8);
    chk("def_tick0", c_tick[0], 4);
    chk("def_high0", c_high[0], 4);
    chk("def_high1", c_high[1], 0);

    // glitch-free update mid-period
    wr(0, 10, 5);
    wait_tick(0, 10);
    repeat (3) cycle();
    cfg_ch = 2'd0; cfg_div = 8'd4; cfg_duty = 8'd1; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    chk("glitch_ready_low", cfg_ready, 0);
    chk("glitch_seq0", clk_out[0], exp_seq[13]);
    for (int k = 1; k < 14; k++) begin
      cycle();
      chk($sformatf("glitch_seq%0d", k), clk_out[0], exp_seq[13-k]);
    end

    // backpressure on one channel, acceptance on another
    ch_en = 3'b011;
    wait_tick(0, 4);
    cfg_ch = 2'd0; cfg_div = 8'd6; cfg_duty = 8'd3; cfg_valid = 1'b1;
    #1 chk("bp_first_ready", cfg_ready, 1);
    cycle();
    cfg_div = 8'd7; cfg_duty = 8'd2;
    #1 chk("bp_second_blocked", cfg_ready, 0);
    cycle();
    cfg_ch = 2'd1; cfg_div = 8'd5; cfg_duty = 8'd2;
    #1 chk("bp_other_ready", cfg_ready, 1);
    cycle();
    cfg_valid = 1'b0;
    repeat (12) cycle();
    count(30);
    chk("bp_tick0", c_tick[0], 5);
    chk("bp_high0", c_high[0], 15);
    chk("bp_tick1", c_tick[1], 6);
    chk("bp_high1", c_high[1], 12);

    // extremes
    ch_en = 3'b111;
    wr(1, 0, 1);
    wr(2, 5, 0);
    wr(0, 3, 7);
    repeat (12) cycle();
    count(9);
    chk("ext_div0_tick", c_tick[1], 9);
    chk("ext_duty0_high", c_high[2], 0);
    chk("ext_full_high", c_high[0], 9);
    chk("ext_full_tick", c_tick[0], 3);

    // enable gating
    wait_tick(0, 3);
    cycle();
    ch_en[0] = 1'b0;
    cycle();
    chk("gate_low", clk_out[0], 0);
    chk("gate_tick", tick[0], 0);
    repeat (2) cycle();
    ch_en[0] = 1'b1;
    cycle();
    chk("reen_tick", tick[0], 1);
    chk("reen_high", clk_out[0], 1);
    cycle(); chk("reen_p1", tick[0], 0);
    cycle(); chk("reen_p2", tick[0], 0);
    cycle(); chk("reen_p3", tick[0], 1);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) ch_en = NCH'($urandom);
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_div   = WIDTH'($urandom_range(0, 7));
      cfg_duty  = WIDTH'($urandom_range(0, 8));
      cycle();
    end
    cfg_valid = 1'b0;

    // asynchronous reset with a write pending
    ch_en = 3'b111;
    wr(0, 9, 4);
    wait_tick(0, 9);
    wr(0, 2, 2);
    chk("rst_pending", cfg_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_ready", cfg_ready, 1);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
    count(8);
    chk("post_rst_tick0", c_tick[0], 4);
    chk("post_rst_high0", c_high[0], 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
